// File: rtl/watchdog_kick_gen.sv
// Feed-side controller for the auto-reset watchdog: arms, kicks on liveness.
// Optional WDT_KICK_GEN_HB_BYPASS_EN removes heartbeat gating (no STALL).
module watchdog_kick_gen #(
  parameter int unsigned ARM_DELAY_CYCLES = 100_000_000,
  parameter int unsigned KICK_PERIOD      = 50_000_000,
  parameter int unsigned KICK_WIDTH       = 4,
  parameter int unsigned HB_WINDOW        = 200_000_000,
  parameter int unsigned HOLDOFF_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        heartbeat,
  input  logic        wdt_reset,
  output logic        watch_dog_counter_start_signal,
  output logic        watch_dog_signal,
  output logic [15:0] kick_count,
  output logic        hb_stale,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    STALL   = 3'd3,
    HOLDOFF = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] arm_cnt_q;
  logic [31:0] period_cnt_q;
  logic [31:0] hb_age_q;
  logic [31:0] holdoff_cnt_q;
  logic [15:0] kick_cnt_q;
  logic [3:0]  width_q;
  logic        kick_q;
  logic        start_q;
  logic        pend_q;

  logic        hb_in;
  logic        hb_ok;
  logic        period_end;
  logic        fire;
  logic [31:0] hb_age_inc;

`ifdef WDT_KICK_GEN_HB_BYPASS_EN
  logic unused_hb;
  assign unused_hb = heartbeat;
  assign hb_in     = 1'b0;
  assign hb_ok     = 1'b1;
  assign hb_stale  = 1'b0;
`else
  assign hb_in     = heartbeat;
  // a heartbeat in the expiry cycle counts as age 0
  assign hb_ok     = hb_in || (hb_age_q < HB_WINDOW);
  assign hb_stale  = (state_q == STALL);
`endif

  assign period_end = (period_cnt_q == KICK_PERIOD - 1);
  assign hb_age_inc = (hb_age_q >= HB_WINDOW) ? HB_WINDOW
                                              : hb_age_q + 32'd1;

  assign fire = enable && !wdt_reset && (state_q == RUN)
             && (pend_q || (period_end && hb_ok));

  assign watch_dog_counter_start_signal = start_q;
  assign watch_dog_signal = kick_q;
  assign kick_count       = kick_cnt_q;
  assign state            = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      arm_cnt_q     <= '0;
      period_cnt_q  <= '0;
      hb_age_q      <= '0;
      holdoff_cnt_q <= '0;
      kick_cnt_q    <= '0;
      width_q       <= '0;
      kick_q        <= 1'b0;
      start_q       <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      pend_q <= 1'b0;
      if (kick_q) begin
        if (width_q == 4'd0) kick_q <= 1'b0;
        else width_q <= width_q - 4'd1;
      end
      if (fire) begin
        kick_q  <= 1'b1;
        width_q <= 4'(KICK_WIDTH - 1);
        if (kick_cnt_q != 16'hFFFF)
          kick_cnt_q <= kick_cnt_q + 16'd1;
      end
      // later assignments override the kick pulse above
      if (!enable) begin
        state_q       <= IDLE;
        start_q       <= 1'b0;
        kick_q        <= 1'b0;
        arm_cnt_q     <= '0;
        period_cnt_q  <= '0;
        hb_age_q      <= '0;
        holdoff_cnt_q <= '0;
      end else if (wdt_reset && state_q != IDLE) begin
        state_q       <= HOLDOFF;
        start_q       <= 1'b0;
        kick_q        <= 1'b0;
        holdoff_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q   <= ARM;
            arm_cnt_q <= '0;
          end
          ARM: begin
            if (arm_cnt_q == ARM_DELAY_CYCLES - 1) begin
              state_q      <= RUN;
              start_q      <= 1'b1;
              period_cnt_q <= '0;
              hb_age_q     <= '0;
            end else begin
              arm_cnt_q <= arm_cnt_q + 32'd1;
            end
          end
          RUN: begin
            hb_age_q <= hb_in ? 32'd0 : hb_age_inc;
            if (period_end) begin
              period_cnt_q <= '0;
              if (!hb_ok) state_q <= STALL;
            end else begin
              period_cnt_q <= period_cnt_q + 32'd1;
            end
          end
          STALL: begin
            if (hb_in) begin
              state_q      <= RUN;
              period_cnt_q <= '0;
              hb_age_q     <= '0;
              pend_q       <= 1'b1;
            end
          end
          HOLDOFF: begin
            if (holdoff_cnt_q == HOLDOFF_CYCLES - 1) begin
              state_q   <= ARM;
              arm_cnt_q <= '0;
            end else begin
              holdoff_cnt_q <= holdoff_cnt_q + 32'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
